// File: rtl/button_pkg.sv
// Shared types and sizes for the front-panel button event path.
package button_pkg;

  localparam int unsigned NUM_BUTTONS = 16;
  localparam int unsigned BTN_IDX_W   = 4;
  localparam int unsigned DB_CNT_W    = 8;

  typedef enum logic {IDLE, OFFER} arb_state_t;
  typedef logic [BTN_IDX_W-1:0] btn_idx_t;

endpackage

// File: rtl/button_debounce.sv
// Single-button debouncer: a new synchronised level must persist for
// DEBOUNCE_TICKS sample ticks before it replaces the stable level.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic syncIn,
  output logic stable
);

  localparam logic [DB_CNT_W-1:0] LAST_CNT = DB_CNT_W'(DEBOUNCE_TICKS - 1);

  logic [DB_CNT_W-1:0] r_count;

  // Any return to the stable level restarts the persistence count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable  <= 1'b0;
      r_count <= '0;
    end else if (syncIn == stable) begin
      r_count <= '0;
    end else if (tick) begin
      if (r_count == LAST_CNT) begin
        stable  <= syncIn;
        r_count <= '0;
      end else begin
        r_count <= r_count + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Button front end: synchronise, debounce, latch one pending press per button
// and serve presses round-robin over a 4-bit valid/ready channel.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] rawButtons,
  input  logic                   eventReady,
  input  logic                   clearMissed,
  output logic                   eventValid,
  output btn_idx_t               buttonNum,
  output logic [NUM_BUTTONS-1:0] stableButtons,
  output logic                   missedEvent
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]      r_tick_cnt;
  logic                   w_tick;
  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] r_stable_d;
  logic [NUM_BUTTONS-1:0] r_pending;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_clear;
  logic                   w_accept;
  logic                   w_lost;
  logic                   w_found;
  btn_idx_t               w_winner;
  btn_idx_t               r_last_grant;
  arb_state_t             r_state;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_db
    button_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (w_tick),
      .syncIn (r_sync2[g]),
      .stable (stableButtons[g])
    );
  end

  assign w_press  = stableButtons & ~r_stable_d;
  assign w_accept = eventValid & eventReady;
  // A press on a button still pending (and not being consumed now) is lost
  assign w_lost   = |(w_press & r_pending & ~w_clear);

  always_comb begin
    w_clear = '0;
    if (w_accept) w_clear[buttonNum] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable_d <= '0;
      r_pending  <= '0;
    end else begin
      r_sync1    <= rawButtons;
      r_sync2    <= r_sync1;
      r_stable_d <= stableButtons;
      r_pending  <= (r_pending & ~w_clear) | w_press;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missedEvent <= 1'b0;
    end else if (w_lost) begin
      missedEvent <= 1'b1;
    end else if (clearMissed) begin
      missedEvent <= 1'b0;
    end
  end

  // Round-robin search starting just after the last granted button
  always_comb begin
    btn_idx_t cand;
    cand     = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_BUTTONS; k++) begin
      cand = r_last_grant + BTN_IDX_W'(k);
      if (!w_found && r_pending[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      eventValid   <= 1'b0;
      buttonNum    <= '0;
      r_last_grant <= BTN_IDX_W'(NUM_BUTTONS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            buttonNum  <= w_winner;
            eventValid <= 1'b1;
            r_state    <= OFFER;
          end
        end
        OFFER: begin
          if (eventReady) begin
            r_last_grant <= buttonNum;
            eventValid   <= 1'b0;
            r_state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench: directed scenarios plus random button activity, all
// compared cycle by cycle against a behavioural model of the button rules.
module tb_button_event_arbiter;

  localparam int TD = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] rawButtons;
  logic        eventReady;
  logic        clearMissed;
  logic        eventValid;
  logic [3:0]  buttonNum;
  logic [15:0] stableButtons;
  logic        missedEvent;

  button_event_arbiter #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rawButtons   (rawButtons),
    .eventReady   (eventReady),
    .clearMissed  (clearMissed),
    .eventValid   (eventValid),
    .buttonNum    (buttonNum),
    .stableButtons(stableButtons),
    .missedEvent  (missedEvent)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_q[$];
  int acc_t[$];

  // Behavioural reference state
  bit [15:0] m_s1, m_s2, m_stable, m_prev, m_pending;
  int        m_dcnt[16];
  int        m_tcnt;
  bit        m_valid;
  int        m_num, m_last;
  bit        m_missed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_pending = '0;
    foreach (m_dcnt[i]) m_dcnt[i] = 0;
    m_tcnt = 0; m_valid = 0; m_num = 0; m_last = 15; m_missed = 0;
  endtask

  task automatic m_step();
    bit        tick, lost, found;
    bit [15:0] press, clr, nstable;
    tick    = (m_tcnt == TD - 1);
    nstable = m_stable;
    for (int i = 0; i < 16; i++) begin
      if (m_s2[i] == m_stable[i]) m_dcnt[i] = 0;
      else if (tick) begin
        m_dcnt[i]++;
        if (m_dcnt[i] == DT) begin
          nstable[i] = m_s2[i];
          m_dcnt[i]  = 0;
        end
      end
    end
    press = m_stable & ~m_prev;
    clr   = '0;
    if (m_valid && eventReady) clr[m_num] = 1'b1;
    lost  = |(press & m_pending & ~clr);
    if (m_valid) begin
      if (eventReady) begin
        m_valid = 0;
        m_last  = m_num;
      end
    end else begin
      found = 0;
      for (int k = 1; k <= 16; k++) begin
        if (!found && m_pending[(m_last + k) % 16]) begin
          found   = 1;
          m_num   = (m_last + k) % 16;
          m_valid = 1;
        end
      end
    end
    m_pending = (m_pending & ~clr) | press;
    m_missed  = lost | (m_missed & !clearMissed);
    m_prev    = m_stable;
    m_stable  = nstable;
    m_s2      = m_s1;
    m_s1      = rawButtons;
    m_tcnt    = (m_tcnt + 1) % TD;
  endtask

  task automatic compare_all();
    check("stable", 32'(stableButtons), 32'(m_stable));
    check("valid", 32'(eventValid), 32'(m_valid));
    check("missed", 32'(missedEvent), 32'(m_missed));
    if (m_valid) check("num", 32'(buttonNum), 32'(m_num));
  endtask

  task automatic cycle();
    if (eventValid && eventReady) begin
      acc_q.push_back(int'(buttonNum));
      acc_t.push_back(cyc);
    end
    @(posedge clk);
    m_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!eventValid && k < budget) begin
      cycle();
      k++;
    end
    check("wait_valid", 32'(eventValid), 32'd1);
  endtask

  initial begin
    int exp_rr[3] = '{12, 3, 9};
    reset_n     = 1'b0;
    rawButtons  = 16'hFFFF;
    eventReady  = 1'b1;
    clearMissed = 1'b0;
    m_reset();

    // Reset with all buttons held, then sweep 0..15 every 2 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(eventValid), 32'd0);
    check("rst_num", 32'(buttonNum), 32'd0);
    check("rst_stable", 32'(stableButtons), 32'd0);
    check("rst_missed", 32'(missedEvent), 32'd0);
    reset_n = 1'b1;
    run(14);
    check("rel_stable", 32'(stableButtons), 32'hFFFF);
    run(40);
    check("sweep_count", 32'(acc_q.size()), 32'd16);
    for (int i = 0; i < acc_q.size(); i++) check("sweep_order", 32'(acc_q[i]), 32'(i));
    for (int i = 1; i < acc_t.size(); i++) check("sweep_gap", 32'(acc_t[i] - acc_t[i-1]), 32'd2);
    rawButtons = '0;
    run(30);

    // Glitch rejection, then a real press on button 5
    acc_q.delete();
    rawButtons[5] = 1'b1;
    run(7);
    rawButtons[5] = 1'b0;
    run(30);
    check("glitch_events", 32'(acc_q.size()), 32'd0);
    rawButtons[5] = 1'b1;
    run(20);
    rawButtons[5] = 1'b0;
    run(30);
    check("press5_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("press5_num", 32'(acc_q[0]), 32'd5);

    // Round robin from last grant 9
    rawButtons[9] = 1'b1;
    run(20);
    rawButtons[9] = 1'b0;
    run(30);
    acc_q.delete();
    rawButtons = 16'h1208;
    run(20);
    rawButtons = '0;
    run(30);
    check("rr_count", 32'(acc_q.size()), 32'd3);
    for (int i = 0; i < acc_q.size() && i < 3; i++) check("rr_order", 32'(acc_q[i]), 32'(exp_rr[i]));

    // Backpressure on button 7
    eventReady    = 1'b0;
    rawButtons[7] = 1'b1;
    wait_valid(40);
    check("bp_num", 32'(buttonNum), 32'd7);
    rawButtons[7] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      check("bp_hold_valid", 32'(eventValid), 32'd1);
      check("bp_hold_num", 32'(buttonNum), 32'd7);
    end
    acc_q.delete();
    eventReady = 1'b1;
    cycle();
    check("bp_accept_valid", 32'(eventValid), 32'd0);
    run(10);
    check("bp_accept_count", 32'(acc_q.size()), 32'd1);

    // Lost press on button 2
    eventReady    = 1'b0;
    rawButtons[2] = 1'b1;
    run(20);
    rawButtons[2] = 1'b0;
    run(20);
    rawButtons[2] = 1'b1;
    run(20);
    check("lost_flag", 32'(missedEvent), 32'd1);
    rawButtons[2] = 1'b0;
    acc_q.delete();
    eventReady = 1'b1;
    run(30);
    check("lost_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("lost_num", 32'(acc_q[0]), 32'd2);
    clearMissed = 1'b1;
    cycle();
    clearMissed = 1'b0;
    check("lost_clear", 32'(missedEvent), 32'd0);

    // Reset while offering button 4
    eventReady    = 1'b0;
    rawButtons[4] = 1'b1;
    wait_valid(40);
    check("mid_num", 32'(buttonNum), 32'd4);
    rawButtons[4] = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_async_valid", 32'(eventValid), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    eventReady = 1'b1;
    acc_q.delete();
    run(60);
    check("mid_no_replay", 32'(acc_q.size()), 32'd0);

    // Random activity against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rawButtons[$urandom_range(0, 15)] ^= 1'b1;
      eventReady  = ($urandom_range(0, 3) != 0);
      clearMissed = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
